// File: rtl/fetch_if.sv
// Signal bundle between the instruction-fetch stage and its environment:
// instruction-memory port, decode-side controls and the IF/ID register outputs.
interface fetch_if;
  logic [15:0] im_a;
  logic [15:0] im_rd;
  logic        stall;
  logic        redir_en;
  logic [15:0] redir_pc;
  logic        halt;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pcplus1;
  logic        ifid_valid;
  logic [15:0] fetch_count;
  logic [1:0]  state;

  modport master (
    output im_a, ifid_instr, ifid_pc, ifid_pcplus1, ifid_valid, fetch_count, state,
    input  im_rd, stall, redir_en, redir_pc, halt
  );

  modport slave (
    input  im_a, ifid_instr, ifid_pc, ifid_pcplus1, ifid_valid, fetch_count, state,
    output im_rd, stall, redir_en, redir_pc, halt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall, redirect (one bubble) and halt handling.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'd0,
  parameter int          ADDR_LIMIT = 64,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  // Power-of-two depth lets the modulo wrap be a simple mask.
  localparam logic [15:0] ADDR_MASK = 16'(ADDR_LIMIT - 1);

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic [15:0] plus1_q, plus1_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pc_inc;

  assign pc_inc = (pc_q + 16'd1) & ADDR_MASK;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      ifid_pc_q <= 16'd0;
      plus1_q   <= 16'd0;
      valid_q   <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      plus1_q   <= plus1_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  // NOTE: every output of this block gets a hold default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    plus1_d   = plus1_q;
    valid_d   = valid_q;
    count_d   = count_q;

    case (state_q)
      BOOT: state_d = RUN;

      RUN: begin
        if (bus.redir_en) begin
          // Squash the word being fetched; the PC fields keep their old values.
          pc_d    = bus.redir_pc & ADDR_MASK;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          // Hold everything; decode keeps HALT asserted until the stall clears.
        end else if (bus.halt) begin
          state_d = HALTED;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else begin
          instr_d   = bus.im_rd;
          ifid_pc_d = pc_q;
          plus1_d   = pc_inc;
          valid_d   = 1'b1;
          pc_d      = pc_inc;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end

      HALTED: begin
      end

      default: state_d = BOOT;
    endcase
  end

  assign bus.im_a         = pc_q;
  assign bus.ifid_instr   = instr_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_pcplus1 = plus1_q;
  assign bus.ifid_valid   = valid_q;
  assign bus.fetch_count  = count_q;
  assign bus.state        = state_q;

endmodule
